ps2_keyboard_rx: RTL and testbench

- PS/2 keyboard receiver that deserialises device-to-host frames on ps2_clk/ps2_data into 8-bit scan codes.
- Valid codes go into a small receive FIFO; the system-side consumer pops them with an active-low nextdata_n strobe.
- Sits between the PS/2 pins and the keyboard/scan-code handling logic in the top level.

---
 rtl/ps2_pkg.sv | 7 +
 rtl/ps2_rx_fifo.sv | 39 +++
 rtl/ps2_keyboard_rx.sv | 68 ++++++
 tb/tb_ps2_keyboard_rx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants and the scan-code type.
package ps2_pkg;
  localparam int FRAME_BITS = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef logic [7:0] scan_code_t;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: circular scan-code FIFO (2**AW slots, AW-bit wrapping pointers) with sticky overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  scan_code_t i_data,
  output scan_code_t o_data,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overflow
);
  logic [AW-1:0] r_wr, r_rd;
  logic          r_ovf;
  scan_code_t    r_mem [2**AW];
  logic          w_wr_en, w_rd_en;
  assign o_empty = r_wr == r_rd;
  assign o_full = AW'(r_wr + 1'b1) == r_rd;
  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  assign o_overflow = r_ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= AW'(r_wr + 1'b1);
      if (w_rd_en) r_rd <= AW'(r_rd + 1'b1);
      if (i_push & o_full) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr_en) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host frame receiver feeding a scan-code FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [3:0]             r_cnt;
  logic                   r_push;
  scan_code_t             r_byte;
  logic                   w_fall, w_last, w_ok, w_empty, w_full;
  logic [FRAME_BITS-1:0]  w_frame;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_clk_sync <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
  assign w_frame = {r_data_sync[SYNC_STAGES-1], r_shift[FRAME_BITS-1:1]};
  assign w_last = r_cnt == 4'(FRAME_BITS - 1);
`ifdef PS2_PARITY_CHECK_EN
  assign w_ok = w_frame[0] == START_BIT && w_frame[10] == STOP_BIT && ^w_frame[9:1];
`else
  assign w_ok = w_frame[0] == START_BIT && w_frame[10] == STOP_BIT;
`endif
  // The accepted byte is registered so the FIFO write lands one cycle after the final strobe.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_shift <= '0;
      r_cnt <= '0;
      r_push <= 1'b0;
      r_byte <= '0;
    end else begin
      r_push <= w_fall & w_last & w_ok;
      if (w_fall) begin
        r_shift <= w_frame;
        r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        r_byte <= w_frame[8:1];
      end
    end
  ps2_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (r_push),
    .i_pop     (~nextdata_n),
    .i_data    (r_byte),
    .o_data    (data),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_overflow(overflow)
  );
  assign ready = ~w_empty;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: table-driven, directed and random frames checked against a queue model.
module tb_ps2_keyboard_rx;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, nextdata_n = 1;
  logic [7:0] data;
  logic ready, overflow;
  int checks = 0, errors = 0, half = 50;
  logic [7:0] q[$];
  logic ovf = 0;

  ps2_keyboard_rx dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] code; int kind;} vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop = 0, 3 start = 1
  function automatic logic [10:0] mk(input logic [7:0] c, input int kind);
    logic par = ~^c;
    if (kind == 1) par = ~par;
    return {kind == 2 ? 1'b0 : 1'b1, par, c, kind == 3 ? 1'b1 : 1'b0};
  endfunction

  function automatic bit accepted(input int kind);
`ifdef PS2_PARITY_CHECK_EN
    return kind == 0;
`else
    return kind == 0 || kind == 1;
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] b, input int n, output int lat);
    logic pre;
    lat = -1;
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      wait_clk(half / 2);
      pre = ready;
      ps2_clk = 0;
      for (int k = 1; k <= half; k++) begin
        @(negedge clk);
        if (i == 10 && lat < 0 && ready && !pre) lat = k;
      end
      ps2_clk = 1;
      wait_clk(half - half / 2);
    end
    wait_clk(8);
  endtask

  task automatic send(input logic [7:0] c, input int kind);
    int lat;
    send_bits(mk(c, kind), 11, lat);
    if (accepted(kind)) begin
      if (q.size() < 7) q.push_back(c);
      else ovf = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ready"}, ready, q.size() != 0);
    chk({tag, "_ovf"}, overflow, ovf);
    if (q.size() != 0) chk({tag, "_data"}, data, q[0]);
  endtask

  task automatic pop(input int n);
    @(negedge clk);
    nextdata_n = 0;
    wait_clk(n);
    nextdata_n = 1;
    for (int i = 0; i < n; i++) if (q.size() != 0) void'(q.pop_front());
    wait_clk(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    wait_clk(2);
    chk("rst_ready", ready, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", overflow, 0);
    q.delete();
    ovf = 0;
    rst = 0;
    wait_clk(4);
  endtask

  initial begin
    int lat;
    tbl[0] = '{8'h1C, 0}; tbl[1] = '{8'hF0, 0}; tbl[2] = '{8'h1C, 1}; tbl[3] = '{8'h1C, 2};
    tbl[4] = '{8'h1C, 3}; tbl[5] = '{8'h5A, 0}; tbl[6] = '{8'h00, 0}; tbl[7] = '{8'hFF, 0};
    do_reset();
    // latency of the first frame into an empty FIFO
    send_bits(mk(8'h1C, 0), 11, lat);
    q.push_back(8'h1C);
    chk("latency_ok", lat >= 1 && lat <= 5, 1);
    check_state("t1");
    pop(1);
    check_state("t1_pop");
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].code, tbl[i].kind);
      check_state($sformatf("tbl%0d", i));
      while (q.size() != 0) begin
        pop(1);
        check_state($sformatf("tbl%0d_pop", i));
      end
    end
    // two frames queued, popped in order; pop while empty is ignored
    send(8'hF0, 0);
    send(8'h1C, 0);
    check_state("t2_a");
    pop(1);
    check_state("t2_b");
    pop(1);
    check_state("t2_c");
    pop(3);
    check_state("t2_empty_pop");
    // overflow: eighth byte dropped; level-held pop drains several entries
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    check_state("t5_full");
    pop(3);
    check_state("t5_pop3");
    while (q.size() != 0) begin
      pop(1);
      check_state("t5_drain");
    end
    chk("t5_ovf_sticky", overflow, 1);
    // reset after five bits; reception restarts cleanly
    send_bits(mk(8'h77, 0), 5, lat);
    do_reset();
    send(8'h29, 0);
    check_state("t6");
    pop(1);
    half = 20;
    for (int s = 0; s < 30; s++) begin
      logic [7:0] c = 8'($urandom);
      int kind = $urandom_range(0, 5) > 3 ? int'($urandom_range(1, 3)) : 0;
      send(c, kind);
      check_state($sformatf("rnd%0d", s));
      if ($urandom_range(0, 2) != 0) begin
        pop($urandom_range(1, 2));
        check_state($sformatf("rnd%0d_pop", s));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
